// File: rtl/ace_line_state_tracker.sv
// ACE per-line coherence state tracker (I/UC/UD/SC/SD), one local op or snoop in flight.
// Defining ACE_TRK_FLUSH_EN adds a flush walker (flush_req_i / flush_busy_o).
module ace_line_state_tracker #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 64,
   parameter int NUM_LINES  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
`ifdef ACE_TRK_FLUSH_EN
   input  logic                         flush_req_i,
   output logic                         flush_busy_o,
`endif
   input  logic                         arvalid_i,
   output logic                         arready_o,
   input  logic [ADDR_W-1:0]            araddr_i,
   input  logic                         awvalid_i,
   output logic                         awready_o,
   input  logic [ADDR_W-1:0]            awaddr_i,
   input  logic                         acvalid_i,
   output logic                         acready_o,
   input  logic [ADDR_W-1:0]            acaddr_i,
   input  logic [3:0]                   acsnoop_i,
   output logic                         crvalid_o,
   input  logic                         crready_i,
   output logic [4:0]                   crresp_o,
   output logic                         read_main_mem_o,
   output logic                         read_cache_o,
   output logic                         write_main_mem_o,
   output logic                         write_cache_o,
   output logic [$clog2(NUM_LINES)-1:0] act_idx_o,
   output logic [3*NUM_LINES-1:0]       line_state_o
);
   localparam int OFFS  = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_LINES);

   localparam logic [2:0] LS_I  = 3'd0;
   localparam logic [2:0] LS_UC = 3'd1;
   localparam logic [2:0] LS_UD = 3'd2;
   localparam logic [2:0] LS_SC = 3'd3;
   localparam logic [2:0] LS_SD = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
`ifdef ACE_TRK_FLUSH_EN
      ST_RESP  = 2'd2,
      ST_FLUSH = 2'd3
`else
      ST_RESP  = 2'd2
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       lines_q [NUM_LINES];
   logic             upd_en_s;
   logic [IDX_W-1:0] upd_idx_s;
   logic [2:0]       upd_val_s;
   logic             rd_mm_q, rd_mm_d, rd_c_q, rd_c_d, wr_mm_q, wr_mm_d, wr_c_q, wr_c_d;
   logic [IDX_W-1:0] act_idx_q, act_idx_d;
   logic             crvalid_q, crvalid_d;
   logic [4:0]       crresp_q, crresp_d;
   logic             acready_s, awready_s, arready_s;
   logic [IDX_W-1:0] ac_idx_s, aw_idx_s, ar_idx_s;
   logic [2:0]       ac_cur_s, aw_cur_s, ar_cur_s;
   logic             unused_addr_s;
`ifdef ACE_TRK_FLUSH_EN
   localparam logic [IDX_W:0] FLUSH_END = (IDX_W+1)'(NUM_LINES);
   logic [IDX_W:0]   flush_cnt_q, flush_cnt_d;
   logic [IDX_W-1:0] flush_idx_s;
   assign flush_idx_s  = flush_cnt_q[IDX_W-1:0];
   assign flush_busy_o = (state_q == ST_FLUSH);
`endif

   function automatic logic is_dirty(input logic [2:0] st);
      return (st == LS_UD) || (st == LS_SD);
   endfunction

   function automatic logic is_unique(input logic [2:0] st);
      return (st == LS_UC) || (st == LS_UD);
   endfunction

   // Untagged lines: only the index field of each address selects a line.
   assign ac_idx_s      = acaddr_i[OFFS +: IDX_W];
   assign aw_idx_s      = awaddr_i[OFFS +: IDX_W];
   assign ar_idx_s      = araddr_i[OFFS +: IDX_W];
   assign ac_cur_s      = lines_q[ac_idx_s];
   assign aw_cur_s      = lines_q[aw_idx_s];
   assign ar_cur_s      = lines_q[ar_idx_s];
   assign unused_addr_s = ^{araddr_i, awaddr_i, acaddr_i};

   // Next-state, line update and response decode
   always_comb begin
      state_d   = state_q;
      upd_en_s  = 1'b0;
      upd_idx_s = {IDX_W{1'b0}};
      upd_val_s = LS_I;
      rd_mm_d   = 1'b0;
      rd_c_d    = 1'b0;
      wr_mm_d   = 1'b0;
      wr_c_d    = 1'b0;
      act_idx_d = act_idx_q;
      crvalid_d = crvalid_q;
      crresp_d  = crresp_q;
      acready_s = 1'b0;
      awready_s = 1'b0;
      arready_s = 1'b0;
`ifdef ACE_TRK_FLUSH_EN
      flush_cnt_d = flush_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            acready_s = rst_n;
            awready_s = rst_n && !acvalid_i;
            arready_s = rst_n && !acvalid_i && !awvalid_i;
            if (acvalid_i) begin
               state_d   = ST_EXEC;
               act_idx_d = ac_idx_s;
               upd_idx_s = ac_idx_s;
               crvalid_d = 1'b1;
               case (acsnoop_i)
                  4'b0000: crresp_d = (ac_cur_s == LS_I) ? 5'b00000 : 5'b00001;
                  4'b0001: begin
                     upd_en_s  = is_unique(ac_cur_s);
                     upd_val_s = (ac_cur_s == LS_UD) ? LS_SD : LS_SC;
                     crresp_d  = (ac_cur_s == LS_I) ? 5'b00000 : {is_unique(ac_cur_s), 4'b1001};
                  end
                  4'b0111: begin
                     upd_en_s = 1'b1;
                     crresp_d = (ac_cur_s == LS_I) ? 5'b00000
                              : {is_unique(ac_cur_s), 1'b0, is_dirty(ac_cur_s), 2'b01};
                  end
                  4'b1001: begin
                     upd_en_s = 1'b1;
                     wr_mm_d  = is_dirty(ac_cur_s);
                     crresp_d = 5'b00000;
                  end
                  4'b1101: begin
                     upd_en_s = 1'b1;
                     crresp_d = 5'b00000;
                  end
                  default: crresp_d = 5'b00010;
               endcase
            end else if (awvalid_i) begin
               state_d   = ST_EXEC;
               act_idx_d = aw_idx_s;
               upd_en_s  = 1'b1;
               upd_idx_s = aw_idx_s;
               upd_val_s = LS_UD;
               wr_c_d    = 1'b1;
               rd_mm_d   = (aw_cur_s == LS_I);
            end else if (arvalid_i) begin
               state_d   = ST_EXEC;
               act_idx_d = ar_idx_s;
               upd_en_s  = (ar_cur_s == LS_I);
               upd_idx_s = ar_idx_s;
               upd_val_s = LS_UC;
               rd_mm_d   = (ar_cur_s == LS_I);
               rd_c_d    = (ar_cur_s != LS_I);
            end else begin
`ifdef ACE_TRK_FLUSH_EN
               // Line 0 is retired on the accepting edge so the walk spans NUM_LINES cycles.
               if (flush_req_i) begin
                  state_d     = ST_FLUSH;
                  act_idx_d   = {IDX_W{1'b0}};
                  upd_en_s    = 1'b1;
                  wr_mm_d     = is_dirty(lines_q[0]);
                  flush_cnt_d = (IDX_W+1)'(1);
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
         end
         ST_EXEC: begin
            if (crvalid_q && crready_i) begin
               crvalid_d = 1'b0;
               crresp_d  = 5'b00000;
               state_d   = ST_IDLE;
            end else if (crvalid_q) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (crready_i) begin
               crvalid_d = 1'b0;
               crresp_d  = 5'b00000;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
`ifdef ACE_TRK_FLUSH_EN
         ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_END) begin
               state_d = ST_IDLE;
            end else begin
               act_idx_d   = flush_idx_s;
               upd_en_s    = 1'b1;
               upd_idx_s   = flush_idx_s;
               wr_mm_d     = is_dirty(lines_q[flush_idx_s]);
               flush_cnt_d = flush_cnt_q + (IDX_W+1)'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and registered output state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rd_mm_q   <= 1'b0;
         rd_c_q    <= 1'b0;
         wr_mm_q   <= 1'b0;
         wr_c_q    <= 1'b0;
         act_idx_q <= {IDX_W{1'b0}};
         crvalid_q <= 1'b0;
         crresp_q  <= 5'b00000;
`ifdef ACE_TRK_FLUSH_EN
         flush_cnt_q <= {(IDX_W+1){1'b0}};
`endif
      end else begin
         state_q   <= state_d;
         rd_mm_q   <= rd_mm_d;
         rd_c_q    <= rd_c_d;
         wr_mm_q   <= wr_mm_d;
         wr_c_q    <= wr_c_d;
         act_idx_q <= act_idx_d;
         crvalid_q <= crvalid_d;
         crresp_q  <= crresp_d;
`ifdef ACE_TRK_FLUSH_EN
         flush_cnt_q <= flush_cnt_d;
`endif
      end
   end

   // Coherence state array, single write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= LS_I;
      end else if (upd_en_s) begin
         lines_q[upd_idx_s] <= upd_val_s;
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_pack
      assign line_state_o[3*g +: 3] = lines_q[g];
   end

   assign acready_o        = acready_s;
   assign awready_o        = awready_s;
   assign arready_o        = arready_s;
   assign crvalid_o        = crvalid_q;
   assign crresp_o         = crresp_q;
   assign read_main_mem_o  = rd_mm_q;
   assign read_cache_o     = rd_c_q;
   assign write_main_mem_o = wr_mm_q;
   assign write_cache_o    = wr_c_q;
   assign act_idx_o        = act_idx_q;
endmodule

// File: tb/tb_ace_line_state_tracker.sv
// Scoreboard bench for ace_line_state_tracker: a behavioural coherence model predicts
// action pulses and snoop responses; a monitor pops and compares them as the DUT emits them.
module tb_ace_line_state_tracker;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arvalid = 1'b0, awvalid = 1'b0, acvalid = 1'b0, crready = 1'b0;
   logic [31:0] araddr = 32'd0, awaddr = 32'd0, acaddr = 32'd0;
   logic [3:0]  acsnoop = 4'd0;
   logic        arready, awready, acready, crvalid;
   logic [4:0]  crresp;
   logic        rd_mm, rd_c, wr_mm, wr_c;
   logic [2:0]  act_idx;
   logic [23:0] line_state;
`ifdef ACE_TRK_FLUSH_EN
   logic        flush_req = 1'b0;
   logic        flush_busy;
`endif

   always #5 clk = ~clk;

   ace_line_state_tracker dut (
      .clk(clk), .rst_n(rst_n),
`ifdef ACE_TRK_FLUSH_EN
      .flush_req_i(flush_req), .flush_busy_o(flush_busy),
`endif
      .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr),
      .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
      .acvalid_i(acvalid), .acready_o(acready), .acaddr_i(acaddr), .acsnoop_i(acsnoop),
      .crvalid_o(crvalid), .crready_i(crready), .crresp_o(crresp),
      .read_main_mem_o(rd_mm), .read_cache_o(rd_c), .write_main_mem_o(wr_mm),
      .write_cache_o(wr_c), .act_idx_o(act_idx), .line_state_o(line_state)
   );

   typedef enum logic [2:0] {M_I = 3'd0, M_UC = 3'd1, M_UD = 3'd2, M_SC = 3'd3, M_SD = 3'd4} mst_e;
   typedef struct { logic [3:0] p; int idx; } pulse_t;   // p = {rd_mm, rd_c, wr_mm, wr_c}

   mst_e       mline [8];
   pulse_t     pulse_q [$];
   logic [4:0] resp_q [$];
   int         hs_log [$];
   int         checks = 0, errors = 0;
   int         cr_stall_left = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a / 32'd64) % 32'd8);
   endfunction

   function automatic logic [23:0] model_packed();
      logic [23:0] r;
      r = 24'd0;
      for (int i = 0; i < 8; i++) r[3*i +: 3] = mline[i];
      return r;
   endfunction

   task automatic push_pulse(input logic [3:0] p, input int idx);
      pulse_t e;
      e.p = p;
      e.idx = idx;
      pulse_q.push_back(e);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mline[i] = M_I;
      pulse_q.delete();
      resp_q.delete();
   endtask

   task automatic model_read(input int idx);
      if (mline[idx] == M_I) begin
         push_pulse(4'b1000, idx);
         mline[idx] = M_UC;
      end else begin
         push_pulse(4'b0100, idx);
      end
   endtask

   task automatic model_write(input int idx);
      push_pulse((mline[idx] == M_I) ? 4'b1001 : 4'b0001, idx);
      mline[idx] = M_UD;
   endtask

   task automatic model_snoop(input int idx, input logic [3:0] snp);
      mst_e       s;
      logic       present, uniq, dirty;
      logic [4:0] r;
      s       = mline[idx];
      present = (s != M_I);
      uniq    = (s == M_UC) || (s == M_UD);
      dirty   = (s == M_UD) || (s == M_SD);
      r       = 5'b00000;
      case (snp)
         4'b0000: if (present) r = 5'b00001;
         4'b0001: begin
            if (present) r = {uniq, 1'b1, 1'b0, 1'b0, 1'b1};
            if (s == M_UC) mline[idx] = M_SC;
            if (s == M_UD) mline[idx] = M_SD;
         end
         4'b0111: begin
            if (present) r = {uniq, 1'b0, dirty, 1'b0, 1'b1};
            mline[idx] = M_I;
         end
         4'b1001: begin
            if (dirty) push_pulse(4'b0010, idx);
            mline[idx] = M_I;
         end
         4'b1101: mline[idx] = M_I;
         default: r = 5'b00010;
      endcase
      resp_q.push_back(r);
   endtask

   // Present requests from a clean cycle start; model each handshake at the negedge before it.
   task automatic issue(input bit do_ac, input logic [31:0] ac_a, input logic [3:0] snp,
                        input bit do_aw, input logic [31:0] aw_a,
                        input bit do_ar, input logic [31:0] ar_a);
      int budget, hs, sel;
      budget = 200;
      @(posedge clk); #1;
      acvalid = do_ac; acaddr = ac_a; acsnoop = snp;
      awvalid = do_aw; awaddr = aw_a;
      arvalid = do_ar; araddr = ar_a;
      while ((acvalid || awvalid || arvalid) && budget > 0) begin
         @(negedge clk);
         budget--;
         hs = int'(acvalid && acready) + int'(awvalid && awready) + int'(arvalid && arready);
         if (hs > 0) chk("single_handshake", 64'(hs), 64'd1);
         sel = 3;
         if (acvalid && acready) begin
            model_snoop(idx_of(acaddr), acsnoop); sel = 0;
         end else if (awvalid && awready) begin
            model_write(idx_of(awaddr)); sel = 1;
         end else if (arvalid && arready) begin
            model_read(idx_of(araddr)); sel = 2;
         end
         if (sel != 3) hs_log.push_back(sel);
         @(posedge clk); #1;
         if (sel == 0) acvalid = 1'b0;
         if (sel == 1) awvalid = 1'b0;
         if (sel == 2) arvalid = 1'b0;
      end
      chk("issue_complete", 64'({acvalid, awvalid, arvalid}), 64'd0);
      acvalid = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
   endtask

   task automatic check_lines(input string name);
      @(negedge clk);
      chk(name, 64'(line_state), 64'(model_packed()));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_line_state", 64'(line_state), 64'd0);
      chk("rst_outputs", 64'({crvalid, crresp, rd_mm, rd_c, wr_mm, wr_c, act_idx,
                              acready, awready, arready}), 64'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_readies", 64'({acready, awready, arready}), 64'b111);
   endtask

   // crready: forced low for cr_stall_left cycles of a live response, otherwise random
   initial begin
      forever begin
         @(posedge clk); #1;
         if (crvalid && cr_stall_left > 0) begin
            crready = 1'b0;
            cr_stall_left--;
         end else begin
            crready = ($urandom_range(0, 2) != 0);
         end
      end
   end

   // Monitor: pop expectations whenever the DUT presents a pulse or a response handshake
   initial begin
      pulse_t     e;
      logic [4:0] er;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rd_mm || rd_c || wr_mm || wr_c) begin
               if (pulse_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_pulse actual=%b idx=%0d expected=none",
                           {rd_mm, rd_c, wr_mm, wr_c}, act_idx);
               end else begin
                  e = pulse_q.pop_front();
                  chk("pulse", 64'({rd_mm, rd_c, wr_mm, wr_c}), 64'(e.p));
                  chk("act_idx", 64'(act_idx), 64'(e.idx));
               end
            end
            if (crvalid && crready) begin
               if (resp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_resp actual=%b expected=none", crresp);
               end else begin
                  er = resp_q.pop_front();
                  chk("crresp", 64'(crresp), 64'(er));
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] snp_tbl [5];
      logic [3:0] snp;
      int         pick;
      bit         a, w, r;
      snp_tbl = '{4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1101};
      model_clear();
      do_reset();

      // Local read miss then hit on line 1
      issue(1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1, 32'h40);
      check_lines("read_miss_lines");
      chk("read_miss_pulse", 64'({rd_mm, rd_c, act_idx}), 64'({1'b1, 1'b0, 3'd1}));
      issue(1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1, 32'h40);
      check_lines("read_hit_lines");
      chk("read_hit_pulse", 64'({rd_mm, rd_c}), 64'b01);

      // Write miss to line 2, then ReadShared
      issue(1'b0, 32'd0, 4'd0, 1'b1, 32'h80, 1'b0, 32'd0);
      check_lines("write_lines");
      chk("write_pulse", 64'({rd_mm, wr_c, act_idx}), 64'({1'b1, 1'b1, 3'd2}));
      issue(1'b1, 32'h80, 4'b0001, 1'b0, 32'd0, 1'b0, 32'd0);
      check_lines("readshared_lines");
      chk("readshared_resp", 64'(crresp), 64'b11001);

      // ReadUnique on SD line with crready held low
      @(posedge clk); #1;
      while (crvalid) begin @(posedge clk); #1; end
      cr_stall_left = 3;
      issue(1'b1, 32'h80, 4'b0111, 1'b0, 32'd0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_crvalid", 64'(crvalid), 64'd1);
         chk("stall_crresp", 64'(crresp), 64'b00101);
         chk("stall_readies", 64'({acready, awready, arready}), 64'd0);
      end
      chk("readunique_lines", 64'(line_state), 64'(model_packed()));

      // Simultaneous requests: snoop, then write, then read
      hs_log.delete();
      issue(1'b1, 32'hC0, 4'b0000, 1'b1, 32'h100, 1'b1, 32'h140);
      check_lines("priority_lines");
      chk("priority_order", 64'(hs_log.size() == 3 ? hs_log[0]*100 + hs_log[1]*10 + hs_log[2] : -1),
          64'd12);

      // Unsupported snoop type on UC line 1
      issue(1'b1, 32'h1040, 4'b0010, 1'b0, 32'd0, 1'b0, 32'd0);
      check_lines("error_snoop_lines");
      chk("error_snoop_resp", 64'(crresp), 64'b00010);

      // Randomised traffic with address aliasing
      for (int it = 0; it < 150; it++) begin
         a = ($urandom_range(0, 2) == 0);
         w = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 1) == 0);
         if (!a && !w && !r) r = 1'b1;
         pick = $urandom_range(0, 5);
         snp = (pick == 5) ? 4'($urandom_range(0, 15)) : snp_tbl[pick];
         issue(a, $urandom(), snp, w, $urandom(), r, $urandom());
         check_lines("random_lines");
      end

      repeat (20) @(negedge clk);
      chk("drain_pulses", 64'(pulse_q.size()), 64'd0);
      chk("drain_resps", 64'(resp_q.size()), 64'd0);

      // Reset while a snoop response is stalled
      cr_stall_left = 10;
      issue(1'b1, 32'h80, 4'b0000, 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      chk("pre_reset_crvalid", 64'(crvalid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_crvalid", 64'(crvalid), 64'd0);
      chk("midreset_lines", 64'(line_state), 64'd0);
      model_clear();
      cr_stall_left = 0;
      @(negedge clk);
      rst_n = 1'b1;

`ifdef ACE_TRK_FLUSH_EN
      do_reset();
      issue(1'b0, 32'd0, 4'd0, 1'b1, 32'h000, 1'b0, 32'd0);
      issue(1'b0, 32'd0, 4'd0, 1'b1, 32'h0C0, 1'b0, 32'd0);
      issue(1'b1, 32'h0C0, 4'b0001, 1'b0, 32'd0, 1'b0, 32'd0);
      issue(1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1, 32'h140);
      check_lines("flush_setup_lines");
      @(posedge clk); #1;
      flush_req = 1'b1;
      for (int i = 0; i < 8; i++) if (mline[i] == M_UD || mline[i] == M_SD) push_pulse(4'b0010, i);
      for (int i = 0; i < 8; i++) mline[i] = M_I;
      @(posedge clk); #1;
      flush_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_busy", 64'(flush_busy), 64'd1);
         chk("flush_readies", 64'({acready, awready, arready}), 64'd0);
      end
      @(negedge clk);
      chk("flush_done", 64'(flush_busy), 64'd0);
      chk("flush_lines", 64'(line_state), 64'd0);
`endif

      repeat (20) @(negedge clk);
      chk("final_pulses", 64'(pulse_q.size()), 64'd0);
      chk("final_resps", 64'(resp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
